// File: rtl/tinyodin_pkg.sv
// Shared types and constants for the tinyODIN input stage: scan FSM encoding,
// spike word width and the index-width helper.
package tinyodin_pkg;

    localparam int SPIKE_WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        WAIT_DATA = 3'd2,
        SCAN      = 3'd3,
        DONE      = 3'd4
    } scan_state_t;

    // Never returns 0, so a single-entry range still gets a 1-bit field.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers and a registered read port that
// holds its value between pops.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             underflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign pop_ok    = pop & ~empty;
    // A pop in the same cycle frees the head slot, so a push while full is legal.
    assign push_ok   = push & (~full | pop_ok);
    assign underflow = pop & empty;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rdata  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rdata  <= mem[rd_ptr[PW-1:0]];
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr[PW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/spike_scan_fifo.sv
// Per-timestep spike bitmap fetch, lowest-bit-first index extraction and FIFO
// buffering. Optional spike counter output: define SPIKE_SCAN_COUNT_EN.
module spike_scan_fifo
    import tinyodin_pkg::*;
#(
    parameter  int N     = 256,
    parameter  int DEPTH = 16,
    localparam int IW    = idx_width(N),
    localparam int NW    = N / SPIKE_WORD_W,
    localparam int AW    = idx_width(NW)
) (
    input  logic                    CLK,
    input  logic                    RSTN,
    input  logic                    start_i,
    input  logic                    next_tick_i,
    output logic                    mem_req_o,
    output logic [AW-1:0]           mem_addr_o,
    input  logic [SPIKE_WORD_W-1:0] mem_rdata_i,
    input  logic                    FIFO_r_en_i,
    output logic [IW-1:0]           FIFO_r_data_o,
    output logic                    FIFO_empty_o,
    output logic                    spikecore_done_o,
    output scan_state_t             scan_state_o,
    output logic                    overflow_o
`ifdef SPIKE_SCAN_COUNT_EN
    ,
    output logic [IW:0]             spike_count_o
`endif
);

    scan_state_t             state_q, state_d;
    logic [AW-1:0]           word_q, word_d;
    logic [SPIKE_WORD_W-1:0] scan_q, scan_d;
    logic                    start_q;
    logic                    overflow_q;
    logic                    launch;
    logic                    push;
    logic                    pop_ok;
    logic                    last_word;
    logic [4:0]              bit_sel;
    logic [IW-1:0]           push_idx;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_underflow;

    function automatic logic [4:0] lowest_set(input logic [SPIKE_WORD_W-1:0] v);
        lowest_set = '0;
        for (int i = SPIKE_WORD_W - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = 5'(i);
        end
    endfunction

    // Read handshake: an entry is consumed on a rising edge where FIFO_r_en_i
    // is high and FIFO_empty_o is low; the popped index appears the next cycle.
    assign pop_ok    = FIFO_r_en_i & ~fifo_empty;
    assign last_word = (word_q == AW'(NW - 1));
    assign bit_sel   = lowest_set(scan_q);
    assign push_idx  = IW'({word_q, bit_sel});

    // A start_i edge only counts from IDLE; next_tick_i also relaunches from DONE.
    assign launch = ((state_q == IDLE) && ((start_i && !start_q) || next_tick_i))
                 || ((state_q == DONE) && next_tick_i);

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        scan_d  = scan_q;
        push    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (launch) begin
                    state_d = FETCH;
                    word_d  = '0;
                end
            end
            FETCH: begin
                state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                scan_d = mem_rdata_i;
                if (mem_rdata_i != '0) begin
                    state_d = SCAN;
                end else if (last_word) begin
                    state_d = DONE;
                end else begin
                    word_d  = word_q + AW'(1);
                    state_d = FETCH;
                end
            end
            SCAN: begin
                if (!fifo_full || pop_ok) begin
                    push   = 1'b1;
                    scan_d = scan_q & (scan_q - 32'd1);
                    if (scan_d == '0) begin
                        if (last_word) begin
                            state_d = DONE;
                        end else begin
                            word_d  = word_q + AW'(1);
                            state_d = FETCH;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q    <= IDLE;
            word_q     <= '0;
            scan_q     <= '0;
            start_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            scan_q     <= scan_d;
            start_q    <= start_i;
            overflow_q <= overflow_q | fifo_underflow;
        end
    end

    sync_fifo #(
        .WIDTH (IW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .push      (push),
        .pop       (FIFO_r_en_i),
        .wdata     (push_idx),
        .rdata     (FIFO_r_data_o),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .underflow (fifo_underflow)
    );

    assign mem_req_o        = (state_q == FETCH);
    assign mem_addr_o       = word_q;
    assign FIFO_empty_o     = fifo_empty;
    assign spikecore_done_o = (state_q == DONE);
    assign scan_state_o     = state_q;
    assign overflow_o       = overflow_q;

`ifdef SPIKE_SCAN_COUNT_EN
    logic [IW:0] count_q;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            count_q <= '0;
        end else if (launch) begin
            count_q <= '0;
        end else if (push) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign spike_count_o = count_q;
`endif

endmodule

// File: tb/tb_spike_scan_fifo.sv
// Self-checking bench for spike_scan_fifo: bitmap memory model, scoreboard of
// expected neuron indices, one task per scenario.
module tb_spike_scan_fifo;
    import tinyodin_pkg::*;

    localparam int N     = 256;
    localparam int DEPTH = 16;
    localparam int IW    = 8;
    localparam int NW    = 8;
    localparam int AW    = 3;

    logic              CLK;
    logic              RSTN;
    logic              start_i;
    logic              next_tick_i;
    logic              mem_req_o;
    logic [AW-1:0]     mem_addr_o;
    logic [31:0]       mem_rdata_i;
    logic              FIFO_r_en_i;
    logic [IW-1:0]     FIFO_r_data_o;
    logic              FIFO_empty_o;
    logic              spikecore_done_o;
    scan_state_t       scan_state_o;
    logic              overflow_o;
`ifdef SPIKE_SCAN_COUNT_EN
    logic [IW:0]       spike_count_o;
`endif

    logic [31:0]   bitmap [NW];
    logic [IW-1:0] exp_q [$];
    int            total = 0;
    int            bad   = 0;

    spike_scan_fifo #(.N(N), .DEPTH(DEPTH)) dut (
        .CLK              (CLK),
        .RSTN             (RSTN),
        .start_i          (start_i),
        .next_tick_i      (next_tick_i),
        .mem_req_o        (mem_req_o),
        .mem_addr_o       (mem_addr_o),
        .mem_rdata_i      (mem_rdata_i),
        .FIFO_r_en_i      (FIFO_r_en_i),
        .FIFO_r_data_o    (FIFO_r_data_o),
        .FIFO_empty_o     (FIFO_empty_o),
        .spikecore_done_o (spikecore_done_o),
        .scan_state_o     (scan_state_o),
        .overflow_o       (overflow_o)
`ifdef SPIKE_SCAN_COUNT_EN
        ,
        .spike_count_o    (spike_count_o)
`endif
    );

    // Clock and reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Spike memory: data returned one cycle after the request, junk otherwise
    always @(posedge CLK) begin
        mem_rdata_i <= mem_req_o ? bitmap[mem_addr_o] : 32'hdead_beef;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic reset_dut();
        RSTN        = 1'b0;
        start_i     = 1'b0;
        next_tick_i = 1'b0;
        FIFO_r_en_i = 1'b0;
        for (int w = 0; w < NW; w++) bitmap[w] = '0;
        exp_q.delete();
        repeat (2) @(negedge CLK);
        RSTN = 1'b1;
        @(negedge CLK);
    endtask

    // Pulse next_tick_i for one cycle; returns at the negedge after the launch edge.
    task automatic launch_tick();
        next_tick_i = 1'b1;
        for (int w = 0; w < NW; w++)
            for (int b = 0; b < 32; b++)
                if (bitmap[w][b]) exp_q.push_back(IW'(w * 32 + b));
        @(negedge CLK);
        next_tick_i = 1'b0;
    endtask

    task automatic wait_done(input int start, output int n);
        n = start;
        while (spikecore_done_o !== 1'b1 && n < 300) begin
            @(negedge CLK);
            n++;
        end
    endtask

    task automatic pop_check(input string tag);
        logic [IW-1:0] e;
        FIFO_r_en_i = 1'b1;
        @(negedge CLK);
        FIFO_r_en_i = 1'b0;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: popped %0d but scoreboard is empty", tag, FIFO_r_data_o);
        end else begin
            e = exp_q.pop_front();
            if (FIFO_r_data_o !== e) begin
                bad++;
                $display("FAIL %s: got %0d want %0d", tag, FIFO_r_data_o, e);
            end
        end
    endtask

    task automatic test_reset();
        reset_dut();
        total++; if (scan_state_o !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", scan_state_o, IDLE); end
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL reset_req: got %0b want 0", mem_req_o); end
        total++; if (mem_addr_o !== '0) begin bad++; $display("FAIL reset_addr: got %0d want 0", mem_addr_o); end
        total++; if (FIFO_r_data_o !== '0) begin bad++; $display("FAIL reset_rdata: got %0d want 0", FIFO_r_data_o); end
        total++; if (FIFO_empty_o !== 1'b1) begin bad++; $display("FAIL reset_empty: got %0b want 1", FIFO_empty_o); end
        total++; if (spikecore_done_o !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", spikecore_done_o); end
        total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %0b want 0", overflow_o); end
    endtask

    task automatic test_two_bits();
        int n;
        reset_dut();
        bitmap[0] = 32'h8000_0001;
        launch_tick();
        total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 3'd0) begin bad++; $display("FAIL two_first_req: req=%0b addr=%0d want req=1 addr=0", mem_req_o, mem_addr_o); end
        repeat (2) @(negedge CLK);
        total++; if (FIFO_empty_o !== 1'b1) begin bad++; $display("FAIL two_empty_before_push: got %0b want 1", FIFO_empty_o); end
        @(negedge CLK);
        total++; if (FIFO_empty_o !== 1'b0) begin bad++; $display("FAIL two_empty_after_push: got %0b want 0", FIFO_empty_o); end
        wait_done(4, n);
        total++; if (n != 19) begin bad++; $display("FAIL two_done_latency: got %0d cycles want 19", n); end
        pop_check("two_pop0");
        pop_check("two_pop1");
        total++; if (FIFO_empty_o !== 1'b1) begin bad++; $display("FAIL two_empty_end: got %0b want 1", FIFO_empty_o); end
        total++; if (spikecore_done_o !== 1'b1) begin bad++; $display("FAIL two_done_held: got %0b want 1", spikecore_done_o); end
        total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL two_no_overflow: got %0b want 0", overflow_o); end
`ifdef SPIKE_SCAN_COUNT_EN
        total++; if (spike_count_o !== 9'd2) begin bad++; $display("FAIL two_count: got %0d want 2", spike_count_o); end
`endif
    endtask

    // Runs straight after test_two_bits: FIFO empty, last popped index 31.
    task automatic test_underflow();
        FIFO_r_en_i = 1'b1;
        @(negedge CLK);
        FIFO_r_en_i = 1'b0;
        total++; if (FIFO_r_data_o !== 8'd31) begin bad++; $display("FAIL under_rdata_hold: got %0d want 31", FIFO_r_data_o); end
        total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL under_flag: got %0b want 1", overflow_o); end
        total++; if (FIFO_empty_o !== 1'b1) begin bad++; $display("FAIL under_empty: got %0b want 1", FIFO_empty_o); end
        repeat (3) @(negedge CLK);
        total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL under_sticky: got %0b want 1", overflow_o); end
    endtask

    task automatic test_all_zero();
        int  n;
        logic saw_nonempty;
        reset_dut();
        launch_tick();
        saw_nonempty = 1'b0;
        n = 1;
        while (spikecore_done_o !== 1'b1 && n < 300) begin
            if (FIFO_empty_o !== 1'b1) saw_nonempty = 1'b1;
            @(negedge CLK);
            n++;
        end
        total++; if (n != 2 * NW + 1) begin bad++; $display("FAIL zero_done_latency: got %0d cycles want %0d", n, 2 * NW + 1); end
        total++; if (saw_nonempty !== 1'b0 || FIFO_empty_o !== 1'b1) begin bad++; $display("FAIL zero_no_push: nonempty_seen=%0b empty=%0b want 0/1", saw_nonempty, FIFO_empty_o); end
    endtask

    task automatic test_stall_drain();
        int n;
        int req_cnt;
        reset_dut();
        bitmap[3] = 32'hffff_ffff;
        launch_tick();
        req_cnt = int'(mem_req_o);
        for (int k = 0; k < 44; k++) begin
            @(negedge CLK);
            req_cnt += int'(mem_req_o);
        end
        total++; if (req_cnt != 4) begin bad++; $display("FAIL stall_req_count: got %0d want 4", req_cnt); end
        total++; if (scan_state_o !== SCAN || spikecore_done_o !== 1'b0) begin bad++; $display("FAIL stall_state: got state=%0d done=%0b want %0d/0", scan_state_o, spikecore_done_o, SCAN); end
        FIFO_r_en_i = 1'b1;
        for (int i = 0; i < 32; i++) begin
            logic [IW-1:0] e;
            @(negedge CLK);
            if (i == 31) FIFO_r_en_i = 1'b0;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL stall_drain_%0d: popped %0d but scoreboard is empty", i, FIFO_r_data_o);
            end else begin
                e = exp_q.pop_front();
                if (FIFO_r_data_o !== e) begin bad++; $display("FAIL stall_drain_%0d: got %0d want %0d", i, FIFO_r_data_o, e); end
            end
        end
        total++; if (FIFO_empty_o !== 1'b1) begin bad++; $display("FAIL stall_empty_end: got %0b want 1", FIFO_empty_o); end
        wait_done(0, n);
        total++; if (spikecore_done_o !== 1'b1) begin bad++; $display("FAIL stall_done: got %0b want 1", spikecore_done_o); end
`ifdef SPIKE_SCAN_COUNT_EN
        total++; if (spike_count_o !== 9'd32) begin bad++; $display("FAIL stall_count: got %0d want 32", spike_count_o); end
`endif
    endtask

    task automatic test_reset_mid_scan();
        int n;
        reset_dut();
        bitmap[0] = 32'h0000_00f0;
        launch_tick();
        repeat (3) @(negedge CLK);
        RSTN = 1'b0;
        @(negedge CLK);
        total++; if (scan_state_o !== IDLE) begin bad++; $display("FAIL rst_mid_state: got %0d want %0d", scan_state_o, IDLE); end
        total++; if (FIFO_empty_o !== 1'b1) begin bad++; $display("FAIL rst_mid_empty: got %0b want 1", FIFO_empty_o); end
        total++; if (spikecore_done_o !== 1'b0 || mem_req_o !== 1'b0) begin bad++; $display("FAIL rst_mid_outputs: done=%0b req=%0b want 0/0", spikecore_done_o, mem_req_o); end
        RSTN = 1'b1;
        exp_q.delete();
        @(negedge CLK);
        launch_tick();
        total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 3'd0) begin bad++; $display("FAIL rst_mid_rescan: req=%0b addr=%0d want 1/0", mem_req_o, mem_addr_o); end
        wait_done(1, n);
        total++; if (n != 21) begin bad++; $display("FAIL rst_mid_latency: got %0d cycles want 21", n); end
        for (int i = 0; i < 4; i++) pop_check("rst_mid_pop");
    endtask

    task automatic test_tick_ignored();
        int n;
        reset_dut();
        bitmap[1] = 32'h0000_0f00;
        launch_tick();
        repeat (5) @(negedge CLK);
        total++; if (scan_state_o !== SCAN) begin bad++; $display("FAIL tick_in_scan_state: got %0d want %0d", scan_state_o, SCAN); end
        next_tick_i = 1'b1;
        @(negedge CLK);
        next_tick_i = 1'b0;
        wait_done(7, n);
        total++; if (n != 21) begin bad++; $display("FAIL tick_ignored_latency: got %0d cycles want 21", n); end
        for (int i = 0; i < 4; i++) pop_check("tick_pop");
        total++; if (FIFO_empty_o !== 1'b1) begin bad++; $display("FAIL tick_no_dup: empty=%0b want 1", FIFO_empty_o); end
        launch_tick();
        total++; if (spikecore_done_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 3'd0) begin bad++; $display("FAIL tick_relaunch: done=%0b req=%0b addr=%0d want 0/1/0", spikecore_done_o, mem_req_o, mem_addr_o); end
        wait_done(1, n);
        total++; if (n != 21) begin bad++; $display("FAIL tick_relaunch_latency: got %0d cycles want 21", n); end
        for (int i = 0; i < 4; i++) pop_check("tick_relaunch_pop");
    endtask

    task automatic test_start_launch();
        int n;
        reset_dut();
        bitmap[7] = 32'h8000_0000;
        start_i = 1'b1;
        exp_q.push_back(8'd255);
        @(negedge CLK);
        total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL start_launch: req=%0b want 1", mem_req_o); end
        wait_done(1, n);
        total++; if (n != 18) begin bad++; $display("FAIL start_latency: got %0d cycles want 18", n); end
        start_i = 1'b0;
        @(negedge CLK);
        start_i = 1'b1;
        repeat (3) @(negedge CLK);
        total++; if (scan_state_o !== DONE || mem_req_o !== 1'b0) begin bad++; $display("FAIL start_in_done: state=%0d req=%0b want %0d/0", scan_state_o, mem_req_o, DONE); end
        start_i = 1'b0;
        pop_check("start_pop_top_index");
`ifdef SPIKE_SCAN_COUNT_EN
        total++; if (spike_count_o !== 9'd1) begin bad++; $display("FAIL start_count: got %0d want 1", spike_count_o); end
`endif
    endtask

    initial begin
        RSTN        = 1'b0;
        start_i     = 1'b0;
        next_tick_i = 1'b0;
        FIFO_r_en_i = 1'b0;
        test_reset();
        test_two_bits();
        test_underflow();
        test_all_zero();
        test_stall_drain();
        test_reset_mid_scan();
        test_tick_ignored();
        test_start_launch();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
